// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared types and sizing helpers for the PE output path.
//   drain_state_e : state encoding for pe_output_drain (IDLE, STREAM, CLEAR)
//   ceil_div      : integer ceiling division for elaboration-time sizing
//   calc_d        : buffer depth in words for X elements of WORD elements
//                   each (shared with pe_output_buffer)
// ---------------------------------------------------------------------------
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CLEAR  = 2'd2
  } drain_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int calc_d(input int x, input int word);
    return ceil_div(x, word);
  endfunction

endpackage

// File: rtl/pe_drain_lane_mux.sv
// ---------------------------------------------------------------------------
// pe_drain_lane_mux
// Combinational beat/lane selector: picks LANES consecutive elements starting
// at beat*LANES out of the flat buffer snapshot. Lanes whose element index is
// at or beyond X are forced to zero when MASK_EN is set; lanes beyond the end
// of the buffer are always zero.
// Ports:
//   buf_data : NELEM*DATA_WIDTH flat snapshot, element e at [e*DW +: DW]
//   beat     : BW-bit beat index
//   m_data   : LANES*DATA_WIDTH beat payload, lane k at [k*DW +: DW]
// ---------------------------------------------------------------------------
module pe_drain_lane_mux
  import pe_pkg::*;
#(
  parameter int X          = 3072,
  parameter int DATA_WIDTH = 8,
  parameter int NELEM      = 3072,
  parameter int LANES      = 4,
  parameter int BW         = 10,
  parameter bit MASK_EN    = 1'b1
) (
  input  logic [NELEM*DATA_WIDTH-1:0] buf_data,
  input  logic [BW-1:0]               beat,
  output logic [LANES*DATA_WIDTH-1:0] m_data
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the tool infers a latch.
  always_comb begin
    m_data = '0;
    idx    = 0;
    for (int k = 0; k < LANES; k++) begin
      idx = int'(beat) * LANES + k;
      if (idx < NELEM && (!MASK_EN || idx < X)) begin
        m_data[k*DATA_WIDTH +: DATA_WIDTH] = buf_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/pe_output_drain.sv
// ---------------------------------------------------------------------------
// pe_output_drain
// Streams the PE output buffer snapshot out LANES elements per beat over a
// valid/ready interface, then pulses buf_clr/done for one cycle.
// Configuration macro: PE_DRAIN_PAD_EN
//   undefined : pass is ceil(X/LANES) beats, elements >= X are zeroed
//   defined   : pass is D*WORD/LANES beats, padding slots emitted raw
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a pass (honoured only in IDLE)
//   buf_data  : D*WORD*DATA_WIDTH buffer snapshot
//   busy      : high in STREAM and CLEAR
//   done      : one-cycle pulse at pass completion
//   buf_clr   : one-cycle pulse to the buffer's counter reset
//   m_valid, m_ready, m_data, m_last : output beat stream
// ---------------------------------------------------------------------------
module pe_output_drain
  import pe_pkg::*;
#(
  parameter int  X          = 3072,
  parameter int  DATA_WIDTH = 8,
  parameter int  NUM_MACS   = 4,
  parameter int  NUM_ROWS   = 4,
  parameter int  LANES      = 4,
  localparam int WORD       = NUM_ROWS * NUM_MACS,
  localparam int D          = calc_d(X, WORD),
  localparam int NELEM      = D * WORD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NELEM*DATA_WIDTH-1:0] buf_data,
  output logic                        busy,
  output logic                        done,
  output logic                        buf_clr,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANES*DATA_WIDTH-1:0] m_data,
  output logic                        m_last
);

  localparam int NBEATS     = ceil_div(X, LANES);
  localparam int NBEATS_PAD = NELEM / LANES;
  localparam int MAX_BEATS  = (NBEATS > NBEATS_PAD) ? NBEATS : NBEATS_PAD;
  localparam int BW         = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

`ifdef PE_DRAIN_PAD_EN
  localparam int PASS_BEATS = NBEATS_PAD;
  localparam bit MASK_EN    = 1'b0;

  if ((NELEM % LANES) != 0) begin : g_pad_check
    $error("pe_output_drain: D*WORD must be divisible by LANES when padding is emitted");
  end
`else
  localparam int PASS_BEATS = NBEATS;
  localparam bit MASK_EN    = 1'b1;
`endif

  if (LANES < 1) begin : g_lanes_check
    $error("pe_output_drain: LANES must be at least 1");
  end

  localparam logic [BW-1:0] LAST_BEAT = BW'(PASS_BEATS - 1);

  drain_state_e  state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    busy    = 1'b0;
    done    = 1'b0;
    buf_clr = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          beat_d  = '0;
        end
      end
      ST_STREAM: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = last_beat;
        if (m_ready) begin
          if (last_beat) begin
            state_d = ST_CLEAR;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_CLEAR: begin
        // Single-cycle state: tell the buffer to rewind and report completion.
        busy    = 1'b1;
        done    = 1'b1;
        buf_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  pe_drain_lane_mux #(
    .X          (X),
    .DATA_WIDTH (DATA_WIDTH),
    .NELEM      (NELEM),
    .LANES      (LANES),
    .BW         (BW),
    .MASK_EN    (MASK_EN)
  ) u_lane_mux (
    .buf_data (buf_data),
    .beat     (beat_q),
    .m_data   (m_data)
  );

endmodule

// File: tb/tb_pe_output_drain.sv
// ---------------------------------------------------------------------------
// tb_pe_output_drain
// Scoreboard bench for pe_output_drain: a default-size instance driven
// through full passes, backpressure, ignored starts, mid-pass reset and
// back-to-back passes, plus a small X=18 instance for the final-beat masking.
// ---------------------------------------------------------------------------
module tb_pe_output_drain;

  localparam int NB     = 768;
  localparam int NELEM  = 3072;
  localparam int NELEM_S = 20;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NELEM*8-1:0]   buf_data;
  logic                 busy, done, buf_clr, m_valid, m_ready, m_last;
  logic [31:0]          m_data;

  logic                 start_s, m_ready_s;
  logic [NELEM_S*8-1:0] buf_data_s;
  logic                 busy_s, done_s, buf_clr_s, m_valid_s, m_last_s;
  logic [31:0]          m_data_s;

  always #5 clk = ~clk;

  pe_output_drain dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .buf_data (buf_data),
    .busy     (busy),
    .done     (done),
    .buf_clr  (buf_clr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  pe_output_drain #(
    .X          (18),
    .DATA_WIDTH (8),
    .NUM_MACS   (2),
    .NUM_ROWS   (2),
    .LANES      (4)
  ) dut_s (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s),
    .buf_data (buf_data_s),
    .busy     (busy_s),
    .done     (done_s),
    .buf_clr  (buf_clr_s),
    .m_valid  (m_valid_s),
    .m_ready  (m_ready_s),
    .m_data   (m_data_s),
    .m_last   (m_last_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference beat: element e holds e[7:0]; lane k of beat b is element 4b+k.
  function automatic beat_t model_beat(input int b);
    beat_t r;
    for (int k = 0; k < 4; k++) r.data[k*8 +: 8] = 8'((b * 4 + k) & 255);
    r.last = (b == NB - 1);
    return r;
  endfunction

  beat_t sb[$];
  int    hs_cnt = 0;
  int    done_cnt = 0;
  int    clr_cnt = 0;
  logic  stalled = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  // Backpressure generator: pattern 1,0,0,1 when enabled, else always ready.
  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_idx = 0;

  always @(posedge clk) begin
    #1;
    bp_idx  = (bp_idx + 1) % 4;
    m_ready = bp_en ? bp_pat[bp_idx] : 1'b1;
  end

  // Output monitor: pops the scoreboard on each handshake, checks stall hold.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && m_valid) begin
        check("hold_data", m_data, held_data);
        check("hold_last", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
        end
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (done) done_cnt++;
      if (buf_clr) clr_cnt++;
    end
  end

  task automatic push_pass();
    for (int b = 0; b < NB; b++) sb.push_back(model_beat(b));
  endtask

  // Raises start for exactly one sampling edge; returns just after that edge.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns shortly after the negedge of the CLEAR cycle.
  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen", done_cnt != d0, 1);
  endtask

  task automatic run_pass(input logic bp, input string tag);
    int h0, d0, c0;
    h0 = hs_cnt; d0 = done_cnt; c0 = clr_cnt;
    bp_en = bp;
    push_pass();
    pulse_start();
    @(negedge clk);
    check({tag, "_latency"}, m_valid, 1);
    check({tag, "_busy"}, busy, 1);
    wait_done(4000);
    check({tag, "_clear_done"}, {done, buf_clr, m_valid}, 3'b110);
    @(negedge clk);
    check({tag, "_idle_busy"}, {busy, done, buf_clr}, 3'b000);
    check({tag, "_handshakes"}, hs_cnt - h0, NB);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_clr_cnt"}, clr_cnt - c0, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    bp_en = 1'b0;
  endtask

  logic [31:0] exp_s [5];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0, d0, c0, n, nb;
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    start_s = 1'b0; m_ready_s = 1'b1;
    for (int e = 0; e < NELEM; e++) buf_data[e*8 +: 8] = 8'(e & 255);
    for (int e = 0; e < NELEM_S; e++) buf_data_s[e*8 +: 8] = 8'(e);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {busy, done, buf_clr, m_valid, m_last}, 5'b0);
    check("reset_outs_s", {busy_s, done_s, buf_clr_s, m_valid_s, m_last_s}, 5'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Full pass with m_ready held high.
    run_pass(1'b0, "pass1");

    // Backpressure pass.
    run_pass(1'b1, "bp");

    // Start re-pulsed mid-STREAM and during CLEAR must be ignored.
    d0 = done_cnt; c0 = clr_cnt; h0 = hs_cnt;
    push_pass();
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(4000);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("ign_busy", {busy, m_valid}, 2'b00);
    check("ign_done_cnt", done_cnt - d0, 1);
    check("ign_clr_cnt", clr_cnt - c0, 1);
    check("ign_handshakes", hs_cnt - h0, NB);

    // Reset after 10 handshakes.
    h0 = hs_cnt; d0 = done_cnt; c0 = clr_cnt;
    push_pass();
    pulse_start();
    n = 0;
    while (hs_cnt - h0 < 10 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_reached_10", hs_cnt - h0, 10);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs", {m_valid, busy, done, buf_clr}, 4'b0000);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_clr", clr_cnt - c0, 0);
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    run_pass(1'b0, "restart");

    // Back-to-back: second start raised in the IDLE cycle right after done.
    h0 = hs_cnt; d0 = done_cnt;
    push_pass();
    pulse_start();
    wait_done(4000);
    push_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b2b_valid", m_valid, 1);
    wait_done(4000);
    @(negedge clk);
    check("b2b_handshakes", hs_cnt - h0, 2 * NB);
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_sb_empty", sb.size(), 0);

    // Small configuration: X=18 over 5 beats, last beat partially masked.
    exp_s[0] = 32'h03020100;
    exp_s[1] = 32'h07060504;
    exp_s[2] = 32'h0B0A0908;
    exp_s[3] = 32'h0F0E0D0C;
`ifdef PE_DRAIN_PAD_EN
    exp_s[4] = 32'h13121110;
`else
    exp_s[4] = 32'h00001110;
`endif
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    nb = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_valid_s) begin
        if (nb < 5) begin
          check("small_data", m_data_s, exp_s[nb]);
          check("small_last", m_last_s, nb == 4);
        end
        nb++;
      end
    end
    check("small_beats", nb, 5);
    check("small_idle", {busy_s, m_valid_s}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
